// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
package uart_pkg;

    localparam int unsigned DEFAULT_CLOCK_FREQ_OVER_BAUD_RATE = 868;
    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit input.
module sync_ff #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver delivering bytes on a valid/ready stream with
// single-cycle framing-error and overrun pulses.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_OVER_BAUD_RATE = DEFAULT_CLOCK_FREQ_OVER_BAUD_RATE,
    parameter int unsigned SYNC_STAGES               = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int unsigned CntW = $clog2(CLOCK_FREQ_OVER_BAUD_RATE);
    localparam logic [CntW-1:0] CntLast  = CntW'(CLOCK_FREQ_OVER_BAUD_RATE - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLOCK_FREQ_OVER_BAUD_RATE / 2 - 1);

    logic rx_s;

    sync_ff #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_t                 state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      byte_done;
    logic                      stop_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Counter restarts at every sample point so bit timing never drifts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitHigh: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new byte may replace the held one only when the consumer drains it this cycle.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;
        if (byte_done) begin
            if (!valid_q || out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver with an event-scheduled reference model.
module tb_uart_byte_receiver;

    localparam int unsigned CLKS = 434;
    localparam int unsigned SYNC = 2;
    localparam int unsigned H    = CLKS / 2;
    // Edges from driving the start bit to the edge that presents the result.
    localparam int unsigned LAT  = SYNC + 1 + H + 9 * CLKS;

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
        bit          good;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;

    int          errors = 0;
    int          checks = 0;
    int unsigned edges = 0;
    int unsigned last_rise = 0;
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    logic        prev_valid = 1'b0;
    ev_t         ev_q[$];
    logic [7:0]  rcv_q[$];

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;

    uart_byte_receiver #(
        .CLOCK_FREQ_OVER_BAUD_RATE (CLKS),
        .SYNC_STAGES               (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    // Reference model: each frame becomes an event at its computed delivery edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_fe    <= 1'b0;
            m_ov    <= 1'b0;
            ev_q.delete();
        end else begin
            m_fe <= 1'b0;
            m_ov <= 1'b0;
            if (ev_q.size() != 0 && ev_q[0].due == edges + 1) begin
                if (!ev_q[0].good) begin
                    m_fe <= 1'b1;
                    if (m_valid && out_ready) m_valid <= 1'b0;
                end else if (!m_valid || out_ready) begin
                    m_valid <= 1'b1;
                    m_data  <= ev_q[0].data;
                end else begin
                    m_ov <= 1'b1;
                end
                ev_q.delete(0);
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("cycle {valid,fe,ov,data}",
                  {21'd0, out_valid, frame_err, overrun, out_data},
                  {21'd0, m_valid, m_fe, m_ov, m_data});
            if (out_valid && out_ready) rcv_q.push_back(out_data);
            if (out_valid && !prev_valid) last_rise = edges;
            prev_valid = out_valid;
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        int unsigned k;
        k = edges;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        ev_q.push_back('{due: k + LAT, data: b, good: stop_ok});
        drive_bit(stop_ok);
    endtask

    logic [7:0]  hello [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
    int unsigned k0;
    logic [7:0]  a5;

    initial begin
        #1;
        reset = 1'b1;
        tick(5);
        check("reset_state", {21'd0, out_valid, frame_err, overrun, out_data}, 32'd0);
        reset = 1'b0;
        tick(10);

        // Single 'H' with exact latency.
        k0 = edges;
        send_frame(8'h48, 1'b1);
        tick(20);
        check("h_count", rcv_q.size(), 1);
        check("h_data", rcv_q[0], 8'h48);
        check("h_latency", last_rise - k0, 4126);
        check("h_errs", fe_cnt + ov_cnt, 0);
        rcv_q.delete();

        // Back-to-back "Hello\n".
        for (int i = 0; i < 6; i++) send_frame(hello[i], 1'b1);
        tick(20);
        check("hello_count", rcv_q.size(), 6);
        for (int i = 0; i < 6; i++) check("hello_byte", rcv_q[i], hello[i]);
        check("hello_errs", fe_cnt + ov_cnt, 0);
        rcv_q.delete();

        // Short low glitch is rejected.
        rx = 1'b0;
        tick(200);
        rx = 1'b1;
        tick(2 * CLKS);
        check("glitch_count", rcv_q.size(), 0);
        check("glitch_fe", fe_cnt, 0);
        send_frame(8'h5A, 1'b1);
        tick(20);
        check("after_glitch", rcv_q[0], 8'h5A);
        check("after_glitch_n", rcv_q.size(), 1);
        rcv_q.delete();

        // Bad stop bit followed by a held-low break.
        send_frame(8'h55, 1'b0);
        tick(3 * CLKS);
        rx = 1'b1;
        tick(CLKS);
        check("break_fe", fe_cnt, 1);
        check("break_count", rcv_q.size(), 0);
        send_frame(8'h41, 1'b1);
        tick(20);
        check("after_break", rcv_q[0], 8'h41);
        rcv_q.delete();

        // Overrun with the consumer stalled.
        out_ready = 1'b0;
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        tick(20);
        check("ovr_cnt", ov_cnt, 1);
        check("ovr_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h31});
        check("ovr_nohs", rcv_q.size(), 0);
        out_ready = 1'b1;
        tick(3);
        check("ovr_drain", rcv_q.size(), 1);
        check("ovr_drain_data", rcv_q[0], 8'h31);
        check("ovr_drop", out_valid, 1'b0);
        rcv_q.delete();

        // Reset mid-frame while a byte is held.
        out_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        a5 = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(a5[i]);
        rx = a5[3];
        tick(CLKS / 2);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {21'd0, out_valid, frame_err, overrun, out_data}, 32'd0);
        tick(3);
        reset = 1'b0;
        out_ready = 1'b1;
        rx = 1'b1;
        tick(CLKS);
        check("reset_no_pulse", fe_cnt * 16 + ov_cnt, 17);
        rcv_q.delete();
        send_frame(8'hA5, 1'b1);
        tick(20);
        check("post_reset_n", rcv_q.size(), 1);
        check("post_reset", rcv_q[0], 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
